instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle control unit for the 16-bit, 16-word program ROM datapath.
- Owns the program counter and the instruction register, and drives the ROM address.
- Decodes each instruction and sequences the register file, ALU and output port through fixed FETCH/DECODE/EXECUTE/WRITEBACK phases.
- Resolves jmp and br, and supports run/stop control.

Parameters:
- PC_W, 4, program counter / ROM address width (16 words).
- INST_W, 16, instruction width.
- RST_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- run  in  1  level; 1 = execute continuously.
- step  in  1  single-step request pulse (SINGLE_STEP_EN only; ignored otherwise).
- rom_inst  in  16  instruction word from the ROM (combinational read of rom_addr).
- alu_zero  in  1  ALU result == 0, valid in EXECUTE.
- rom_addr  out  4  ROM address, always equal to pc.
- pc  out  4  current program counter.
- rd_sel  out  3  destination/first-operand register, ir[11:9].
- rs_sel  out  3  source register, ir[8:6].
- imm  out  8  immediate, ir[7:0].
- alu_op  out  2  00 pass-rs, 01 add, 10 sub, 11 pass-imm.
- alu_src_imm  out  1  ALU B operand = imm.
- reg_we  out  1  register-file write strobe, 1-cycle pulse.
- out_we  out  1  output-port latch strobe, 1-cycle pulse.
- illegal  out  1  1-cycle pulse on an undefined opcode.
- busy  out  1  high while not IDLE.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, pc=RST_PC, ir=0, zflag=0; all strobes 0; alu_op=00; alu_src_imm=0. Reset mid-instruction aborts with no write or out strobe.
- Opcode map, ir[15:12]:
  - 0000 nop.
  - 0001 load rd,imm: rd=imm.
  - 0010 add rd,rs.
  - 0011 sub rd,rs.
  - 1011 subi rd,imm.
  - 1110 mov rd,rs.
  - 1000 jmp t: pc=ir[11:8].
  - 1100 br t: pc=ir[11:8] if zflag.
  - 1111 out rd.
  - Any other opcode: behaves as nop and pulses illegal in DECODE.
- FSM, one phase per cycle; 4 cycles per instruction; no overlap:
  - IDLE: run=1 -> FETCH.
  - FETCH: ir <= rom_inst (address = pc) -> DECODE.
  - DECODE: rd_sel/rs_sel/imm, alu_op and alu_src_imm become valid and are held through WRITEBACK -> EXECUTE.
  - EXECUTE: for add/sub/subi, zflag <= alu_zero. No other opcode changes zflag. -> WRITEBACK.
  - WRITEBACK:
    - reg_we=1 for load/add/sub/subi/mov; out_we=1 for out.
    - pc <= target for jmp, or for br with zflag=1; otherwise pc <= pc+1, wrapping modulo 16 (15 -> 0).
    - Next state: FETCH if run=1, else IDLE.
- Deasserting run mid-instruction completes the current instruction, then enters IDLE. pc keeps its updated value.
- Strobes are registered on entry to WRITEBACK and last exactly one cycle.
- The 8-bit immediate is zero-extended by the datapath.
- br tests the zflag captured by the most recent arithmetic instruction.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined: in IDLE, a step pulse (with run=0) executes exactly one instruction and returns to IDLE. step outside IDLE is ignored. run has priority when both are high.
- Undefined: the step port exists but is unused; only run controls execution.

Decomposition:
- Package isa_pkg:
  - opcode localparams (OP_NOP, OP_LOAD, OP_ADD, OP_SUB, OP_SUBI, OP_MOV, OP_JMP, OP_BR, OP_OUT).
  - state encoding typedef (IDLE/FETCH/DECODE/EXECUTE/WRITEBACK).
  - ALU op codes.
  - instruction field bit positions.
- One sub-module, instr_decode: combinational, ir -> alu_op, alu_src_imm, write/out/branch/jump/flag-update enables, illegal. The FSM and PC logic remain in instr_sequencer.

Test Plan:
- Reset then run=1 with ROM[0]=0001_1110_0000_0110 (load r7,6) -> rom_addr=0 in FETCH; reg_we pulses in cycle 4 with rd_sel=7, imm=6, alu_op=11; pc=1.
- jmp: ROM[3]=1000_0001_0000_0000 (jmp 1) -> pc=1 after WRITEBACK; no reg_we or out_we.
- br: subi with alu_zero=1 then br 10 -> pc=10. Repeat with alu_zero=0 -> pc advances by 1. A nop between subi and br leaves zflag unchanged.
- Wrap and illegal: pc=15 executing nop -> pc=0. Opcode 0101 -> illegal pulse, then pc+1.
- run dropped during EXECUTE -> WRITEBACK completes (out_we pulses for out r2, rd_sel=2), then IDLE with busy=0. rst_n=0 during DECODE -> pc=0, IDLE, no strobes.
- SINGLE_STEP_EN: run=0 with a step pulse -> exactly one instruction, back to IDLE. Second step -> next instruction.

Source files
------------

// File: rtl/isa_pkg.sv
// ISA definitions shared by the sequencer and its decoder: field positions,
// opcodes, ALU op codes, FSM phases and the decoded-control bundle.
package isa_pkg;

    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 12;
    localparam int unsigned RD_HI  = 11;
    localparam int unsigned RD_LO  = 9;
    localparam int unsigned RS_HI  = 8;
    localparam int unsigned RS_LO  = 6;
    localparam int unsigned IMM_HI = 7;
    localparam int unsigned IMM_LO = 0;
    localparam int unsigned TGT_HI = 11;
    localparam int unsigned TGT_LO = 8;
    localparam int unsigned OPC_W  = OPC_HI - OPC_LO + 1;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_NOP  = 4'b0000;
    localparam opcode_t OP_LOAD = 4'b0001;
    localparam opcode_t OP_ADD  = 4'b0010;
    localparam opcode_t OP_SUB  = 4'b0011;
    localparam opcode_t OP_SUBI = 4'b1011;
    localparam opcode_t OP_MOV  = 4'b1110;
    localparam opcode_t OP_JMP  = 4'b1000;
    localparam opcode_t OP_BR   = 4'b1100;
    localparam opcode_t OP_OUT  = 4'b1111;

    localparam logic [1:0] ALU_PASS_RS  = 2'b00;
    localparam logic [1:0] ALU_ADD      = 2'b01;
    localparam logic [1:0] ALU_SUB      = 2'b10;
    localparam logic [1:0] ALU_PASS_IMM = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK
    } state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_imm;
        logic       reg_we;
        logic       out_we;
        logic       is_jmp;
        logic       is_br;
        logic       flag_upd;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: maps the instruction opcode onto ALU controls
// and the write/out/branch/jump/flag-update enables; flags undefined opcodes.
module instr_decode
    import isa_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output dec_t             dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            OP_NOP: ;
            OP_LOAD: begin
                dec.alu_op      = ALU_PASS_IMM;
                dec.alu_src_imm = 1'b1;
                dec.reg_we      = 1'b1;
            end
            OP_ADD: begin
                dec.alu_op   = ALU_ADD;
                dec.reg_we   = 1'b1;
                dec.flag_upd = 1'b1;
            end
            OP_SUB: begin
                dec.alu_op   = ALU_SUB;
                dec.reg_we   = 1'b1;
                dec.flag_upd = 1'b1;
            end
            OP_SUBI: begin
                dec.alu_op      = ALU_SUB;
                dec.alu_src_imm = 1'b1;
                dec.reg_we      = 1'b1;
                dec.flag_upd    = 1'b1;
            end
            OP_MOV: begin
                dec.alu_op = ALU_PASS_RS;
                dec.reg_we = 1'b1;
            end
            OP_JMP: dec.is_jmp = 1'b1;
            OP_BR:  dec.is_br  = 1'b1;
            OP_OUT: dec.out_we = 1'b1;
            // Undefined opcodes run as nop apart from the illegal flag.
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control unit owning pc and ir.
// Optional macro SINGLE_STEP_EN: a step pulse in IDLE runs one instruction.
module instr_sequencer
    import isa_pkg::*;
#(
    parameter int unsigned PC_W   = 4,
    parameter int unsigned INST_W = 16,
    parameter int unsigned RST_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              alu_zero,
    output logic [PC_W-1:0]   rom_addr,
    output logic [PC_W-1:0]   pc,
    output logic [2:0]        rd_sel,
    output logic [2:0]        rs_sel,
    output logic [7:0]        imm,
    output logic [1:0]        alu_op,
    output logic              alu_src_imm,
    output logic              reg_we,
    output logic              out_we,
    output logic              illegal,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] ir_q, ir_d;
    logic              zflag_q, zflag_d;
    logic              reg_we_q, reg_we_d;
    logic              out_we_q, out_we_d;
    logic              start_req;
    dec_t              dec;

    instr_decode u_decode (
        .opcode (ir_q[OPC_HI:OPC_LO]),
        .dec    (dec)
    );

`ifdef SINGLE_STEP_EN
    assign start_req = run | step;
`else
    logic unused_step;
    assign unused_step = step;
    assign start_req   = run;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        zflag_d  = zflag_q;
        reg_we_d = 1'b0;
        out_we_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_req) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_d    = rom_inst;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (dec.flag_upd) zflag_d = alu_zero;
                // Strobes registered here so they are high for exactly the WRITEBACK cycle.
                reg_we_d = dec.reg_we;
                out_we_d = dec.out_we;
                state_d  = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                if (dec.is_jmp || (dec.is_br && zflag_q)) begin
                    pc_d = PC_W'(ir_q[TGT_HI:TGT_LO]);
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= PC_W'(RST_PC);
            ir_q     <= '0;
            zflag_q  <= 1'b0;
            reg_we_q <= 1'b0;
            out_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            zflag_q  <= zflag_d;
            reg_we_q <= reg_we_d;
            out_we_q <= out_we_d;
        end
    end

    assign rom_addr    = pc_q;
    assign pc          = pc_q;
    assign rd_sel      = ir_q[RD_HI:RD_LO];
    assign rs_sel      = ir_q[RS_HI:RS_LO];
    assign imm         = ir_q[IMM_HI:IMM_LO];
    assign alu_op      = dec.alu_op;
    assign alu_src_imm = dec.alu_src_imm;
    assign reg_we      = reg_we_q;
    assign out_we      = out_we_q;
    assign illegal     = (state_q == ST_DECODE) && dec.illegal;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed programs plus a random
// ROM run, checked against an instruction-level reference model.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, run, step, alu_zero;
    logic [15:0] rom_inst;
    logic [3:0]  rom_addr, pc;
    logic [2:0]  rd_sel, rs_sel;
    logic [7:0]  imm;
    logic [1:0]  alu_op;
    logic        alu_src_imm, reg_we, out_we, illegal, busy;

    logic [15:0] rom [16];
    logic [3:0]  mpc;
    logic        mz;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;
    assign rom_inst = rom[rom_addr];

    instr_sequencer #(.PC_W(4), .INST_W(16), .RST_PC(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .step        (step),
        .rom_inst    (rom_inst),
        .alu_zero    (alu_zero),
        .rom_addr    (rom_addr),
        .pc          (pc),
        .rd_sel      (rd_sel),
        .rs_sel      (rs_sel),
        .imm         (imm),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .reg_we      (reg_we),
        .out_we      (out_we),
        .illegal     (illegal),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference ALU selection from the opcode table.
    function automatic logic [1:0] exp_aop(input logic [3:0] op);
        case (op)
            4'h1:       return 2'b11;
            4'h2:       return 2'b01;
            4'h3, 4'hB: return 2'b10;
            default:    return 2'b00;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; step = 1'b0; alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_strobes", {reg_we, out_we, illegal}, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_src_imm", alu_src_imm, 0);
        check("rst_rd", rd_sel, 0);
        rst_n = 1'b1;
        mpc = 4'd0;
        mz  = 1'b0;
    endtask

    // Entered in the FETCH cycle; leaves one cycle after WRITEBACK.
    task automatic exec_instr(input logic z, input logic drop_run);
        logic [15:0] inst;
        logic [3:0]  op;
        inst = rom[mpc];
        op   = inst[15:12];
        check("fetch_addr", rom_addr, mpc);
        check("fetch_busy", busy, 1);
        @(posedge clk); #1;
        alu_zero = z;
        check("dec_illegal", illegal,
              !(op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'hB, 4'hE, 4'h8, 4'hC, 4'hF}));
        check("dec_rd", rd_sel, inst[11:9]);
        check("dec_rs", rs_sel, inst[8:6]);
        check("dec_imm", imm, inst[7:0]);
        check("dec_alu_op", alu_op, exp_aop(op));
        check("dec_src_imm", alu_src_imm, op inside {4'h1, 4'hB});
        check("dec_strobes", {reg_we, out_we}, 0);
        @(posedge clk); #1;
        check("exe_strobes", {illegal, reg_we, out_we}, 0);
        if (drop_run) run = 1'b0;
        @(posedge clk); #1;
        check("wb_reg_we", reg_we, op inside {4'h1, 4'h2, 4'h3, 4'hB, 4'hE});
        check("wb_out_we", out_we, op == 4'hF);
        check("wb_alu_op", alu_op, exp_aop(op));
        check("wb_rd", rd_sel, inst[11:9]);
        check("wb_illegal", illegal, 0);
        if (op == 4'h8 || (op == 4'hC && mz)) mpc = inst[11:8];
        else                                  mpc = mpc + 4'd1;
        if (op inside {4'h2, 4'h3, 4'hB}) mz = z;
        @(posedge clk); #1;
        check("next_pc", pc, mpc);
        check("next_busy", busy, run);
        check("post_strobes", {reg_we, out_we}, 0);
    endtask

    initial begin
        logic d;
        do_reset();

        // Directed program: load, zflag via subi/nop/br, illegal, jmp, wrap.
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
        rom[0]  = 16'h1E06;
        rom[1]  = 16'hB401;
        rom[3]  = 16'hCA00;
        rom[10] = 16'h5000;
        rom[11] = 16'hB401;
        rom[12] = 16'hC300;
        rom[13] = 16'h2280;
        rom[14] = 16'h8F00;
        run = 1'b1;
        @(posedge clk); #1;
        exec_instr(1'b0, 1'b0);
        exec_instr(1'b1, 1'b0);
        exec_instr(1'b0, 1'b0);
        exec_instr(1'b0, 1'b0);
        exec_instr(1'b0, 1'b0);
        exec_instr(1'b0, 1'b0);
        exec_instr(1'b1, 1'b0);
        exec_instr(1'($urandom_range(0, 1)), 1'b0);
        exec_instr(1'b0, 1'b0);
        exec_instr(1'b0, 1'b1);
        check("wrap_pc", pc, 0);

        // jmp back, then drop run while out executes.
        do_reset();
        rom[0] = 16'h0000; rom[1] = 16'hF400; rom[2] = 16'h0000; rom[3] = 16'h8100;
        run = 1'b1;
        @(posedge clk); #1;
        repeat (4) exec_instr(1'b0, 1'b0);
        check("jmp_pc", pc, 1);
        exec_instr(1'b0, 1'b1);
        @(posedge clk); #1;
        check("stop_idle_busy", busy, 0);
        check("stop_idle_pc", pc, 2);

        // Reset asserted in DECODE aborts the instruction.
        rom[2] = 16'h1234;
        run = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        run = 1'b0;
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_pc", pc, 0);
            check("abort_busy", busy, 0);
            check("abort_strobes", {reg_we, out_we, illegal}, 0);
        end
        rst_n = 1'b1;
        mpc = 4'd0; mz = 1'b0;

        // Random ROM with occasional run drops.
        do_reset();
        for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
        run = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 80; n++) begin
            d = ($urandom_range(0, 7) == 0);
            exec_instr(1'($urandom_range(0, 1)), d);
            if (d) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                    check("rand_idle_busy", busy, 0);
                    check("rand_idle_pc", pc, mpc);
                end
                run = 1'b1;
                @(posedge clk); #1;
            end
        end
        exec_instr(1'b0, 1'b1);

`ifdef SINGLE_STEP_EN
        for (int s = 0; s < 2; s++) begin
            step = 1'b1;
            @(posedge clk); #1;
            step = 1'b0;
            exec_instr(1'($urandom_range(0, 1)), 1'b0);
            repeat (2) begin
                @(posedge clk); #1;
                check("step_idle_busy", busy, 0);
                check("step_idle_pc", pc, mpc);
            end
        end
`else
        step = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("step_ignored_busy", busy, 0);
            check("step_ignored_pc", pc, mpc);
        end
        step = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
